// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared types and constants for the DHT11 read scheduler.
package dht_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } dhtState_t;

  // Field positions inside the 32-bit sample word
  localparam int HUM_INT_MSB = 31;
  localparam int HUM_INT_LSB = 24;
  localparam int HUM_DEC_MSB = 23;
  localparam int HUM_DEC_LSB = 16;
  localparam int TMP_INT_MSB = 15;
  localparam int TMP_INT_LSB = 8;
  localparam int TMP_DEC_MSB = 7;
  localparam int TMP_DEC_LSB = 0;

  localparam int DEFAULT_N_REQ          = 2;
  localparam int DEFAULT_MIN_GAP_CYCLES = 50_000_000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 5_000_000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that saturates at LIMIT.
module sat_counter #(
  parameter int WIDTH       = 8,
  parameter int LIMIT       = 255,
  parameter int RESET_VALUE = 0
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Clear,
  output logic [WIDTH-1:0] o_Count
);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Count <= WIDTH'(RESET_VALUE);
    end else if (i_Clear) begin
      o_Count <= '0;
    end else if (o_Count != WIDTH'(LIMIT)) begin
      o_Count <= o_Count + 1'b1;
    end
  end

endmodule

// File: rtl/dht_read_scheduler.sv
// rtl/dht_read_scheduler.sv - shares one DHT11 reader among several requesters,
// enforcing the minimum read gap and serving recent requests from a cached sample.
module dht_read_scheduler
  import dht_pkg::*;
#(
  parameter int N_REQ          = DEFAULT_N_REQ,
  parameter int MIN_GAP_CYCLES = DEFAULT_MIN_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic [N_REQ-1:0] i_Req,
  output logic [N_REQ-1:0] o_Grant,
  output logic [31:0]      o_Data,
  output logic             o_Error,
  output logic             o_Busy,
  output logic             o_Dht_Start,
  input  logic [31:0]      i_Dht_Data,
  input  logic             i_Dht_Done,
  input  logic             i_Dht_Error
);

  localparam int AGE_W = $clog2(MIN_GAP_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  dhtState_t        state;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] snapshot;
  logic [31:0]      cache;
  logic             cacheValid;
  logic [AGE_W-1:0] age;
  logic [TMO_W-1:0] tmoCount;
  logic             timeout;
  logic             readFail;
  logic             fresh;
  logic             gapExpired;
  logic             tmoClear;

  assign timeout    = (state == WAIT_DONE) && (tmoCount == TMO_W'(TIMEOUT_CYCLES - 1));
  assign readFail   = (state == WAIT_DONE) && (i_Dht_Error || timeout);
  assign fresh      = cacheValid && (age < AGE_W'(MIN_GAP_CYCLES));
  assign gapExpired = (age == AGE_W'(MIN_GAP_CYCLES));
  // Held at zero until START so the timeout spans start pulse to grant
  assign tmoClear   = (state == IDLE) || (state == RESPOND);

  assign o_Busy      = (state == START) || (state == WAIT_DONE);
  assign o_Dht_Start = (state == START);

  sat_counter #(
    .WIDTH      (AGE_W),
    .LIMIT      (MIN_GAP_CYCLES),
    .RESET_VALUE(MIN_GAP_CYCLES)
  ) ageCounter (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Clear(i_Dht_Done || i_Dht_Error || timeout),
    .o_Count(age)
  );

  sat_counter #(
    .WIDTH      (TMO_W),
    .LIMIT      (TIMEOUT_CYCLES),
    .RESET_VALUE(0)
  ) timeoutCounter (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Clear(tmoClear),
    .o_Count(tmoCount)
  );

  // New requests are OR-ed in after the clear so a same-cycle re-request survives
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~((state == RESPOND) ? snapshot : '0)) | i_Req;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= IDLE;
      snapshot   <= '0;
      cache      <= '0;
      cacheValid <= 1'b0;
      o_Grant    <= '0;
      o_Data     <= '0;
      o_Error    <= 1'b0;
    end else begin
      o_Grant <= '0;
      case (state)
        IDLE: begin
          if (pending != '0) begin
            if (fresh) begin
              snapshot <= pending;
              o_Grant  <= pending;
              o_Data   <= cache;
              o_Error  <= 1'b0;
              state    <= RESPOND;
            end else if (gapExpired) begin
              state <= START;
            end
          end
        end
        START: begin
          snapshot <= pending;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (readFail) begin
            cacheValid <= 1'b0;
            o_Grant    <= snapshot;
            o_Data     <= cache;
            o_Error    <= 1'b1;
            state      <= RESPOND;
          end else if (i_Dht_Done) begin
            cache      <= i_Dht_Data;
            cacheValid <= 1'b1;
            o_Grant    <= snapshot;
            o_Data     <= i_Dht_Data;
            o_Error    <= 1'b0;
            state      <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_read_scheduler.sv
// tb/tb_dht_read_scheduler.sv - directed self-checking bench for dht_read_scheduler.
module tb_dht_read_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  grant;
  logic [31:0] data;
  logic        err;
  logic        busy;
  logic        dhtStart;
  logic [31:0] dhtData = '0;
  logic        dhtDone = 1'b0;
  logic        dhtErr = 1'b0;

  int checks = 0;
  int failures = 0;

  int          lat;
  logic        sawStart;
  logic [1:0]  gotGrant;

  always #5 clk = ~clk;

  dht_read_scheduler #(
    .N_REQ         (2),
    .MIN_GAP_CYCLES(100),
    .TIMEOUT_CYCLES(40)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Req      (req),
    .o_Grant    (grant),
    .o_Data     (data),
    .o_Error    (err),
    .o_Busy     (busy),
    .o_Dht_Start(dhtStart),
    .i_Dht_Data (dhtData),
    .i_Dht_Done (dhtDone),
    .i_Dht_Error(dhtErr)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse a request and count negedges until a start (forStart) or any grant appears
  task automatic reqWait(input logic [1:0] mask, input bit forStart,
                         output int l, output logic saw, output logic [1:0] g);
    req = mask;
    l = -1;
    saw = 1'b0;
    g = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      if (dhtStart) saw = 1'b1;
      if (forStart ? dhtStart : (grant != '0)) begin
        l = k;
        g = grant;
        break;
      end
    end
  endtask

  task automatic sendResult(input logic [31:0] d, input logic done, input logic error);
    dhtData = d;
    dhtDone = done;
    dhtErr  = error;
    @(negedge clk);
    dhtDone = 1'b0;
    dhtErr  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ticks(3);
    checkEq("reset_outs", {27'd0, grant, err, busy, dhtStart}, 32'd0);
    checkEq("reset_data", data, 32'd0);
    rst = 1'b0;
    ticks(2);

    // First request reads the sensor immediately
    reqWait(2'b01, 1'b1, lat, sawStart, gotGrant);
    checkEq("a_start_lat", lat, 2);
    checkEq("a_busy", {31'd0, busy}, 1);
    ticks(10);
    sendResult(32'h3700_1A00, 1'b1, 1'b0);
    checkEq("a_grant", {30'd0, grant}, 32'd1);
    checkEq("a_data", data, 32'h3700_1A00);
    checkEq("a_err", {31'd0, err}, 0);

    // Within the gap: cache hit
    ticks(19);
    reqWait(2'b10, 1'b0, lat, sawStart, gotGrant);
    checkEq("b_lat", lat, 2);
    checkEq("b_grant", {30'd0, gotGrant}, 32'd2);
    checkEq("b_nostart", {31'd0, sawStart}, 0);
    checkEq("b_data", data, 32'h3700_1A00);

    // Two requesters in one cycle share a single read
    ticks(110);
    reqWait(2'b11, 1'b1, lat, sawStart, gotGrant);
    checkEq("c_start_lat", lat, 2);
    ticks(1);
    checkEq("c_single_start", {31'd0, dhtStart}, 0);
    ticks(4);
    sendResult(32'h3800_1B05, 1'b1, 1'b0);
    checkEq("c_grant", {30'd0, grant}, 32'd3);
    checkEq("c_data", data, 32'h3800_1B05);
    ticks(1);
    checkEq("c_grant_once", {30'd0, grant}, 32'd0);

    // Request arriving during WAIT_DONE is served from cache afterwards
    ticks(110);
    reqWait(2'b10, 1'b1, lat, sawStart, gotGrant);
    checkEq("d_start_lat", lat, 2);
    ticks(2);
    req = 2'b01;
    ticks(1);
    req = '0;
    ticks(2);
    sendResult(32'h3900_1C06, 1'b1, 1'b0);
    checkEq("d_grant", {30'd0, grant}, 32'd2);
    ticks(1);
    checkEq("d_gap", {30'd0, grant}, 32'd0);
    ticks(1);
    checkEq("d_cache_grant", {30'd0, grant}, 32'd1);
    checkEq("d_cache_data", data, 32'h3900_1C06);
    checkEq("d_nostart", {31'd0, dhtStart}, 0);

    // No answer: timeout 40 cycles after start, stale data
    ticks(110);
    reqWait(2'b01, 1'b1, lat, sawStart, gotGrant);
    checkEq("e_start_lat", lat, 2);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (grant != '0) begin
        lat = k;
        break;
      end
    end
    checkEq("e_tmo_lat", lat, 40);
    checkEq("e_grant", {30'd0, grant}, 32'd1);
    checkEq("e_err", {31'd0, err}, 1);
    checkEq("e_stale", data, 32'h3900_1C06);
    ticks(5);
    reqWait(2'b10, 1'b1, lat, sawStart, gotGrant);
    checkEq("e_gap_lat", lat, 96);
    ticks(3);
    sendResult(32'h2B05_1907, 1'b1, 1'b0);
    checkEq("e_grant2", {30'd0, grant}, 32'd2);
    checkEq("e_data2", data, 32'h2B05_1907);

    // Done and error together: error wins, cache invalidated
    ticks(110);
    reqWait(2'b01, 1'b1, lat, sawStart, gotGrant);
    ticks(3);
    sendResult(32'hDEAD_BEEF, 1'b1, 1'b1);
    checkEq("f_grant", {30'd0, grant}, 32'd1);
    checkEq("f_err", {31'd0, err}, 1);
    checkEq("f_data", data, 32'h2B05_1907);
    ticks(5);
    reqWait(2'b10, 1'b1, lat, sawStart, gotGrant);
    checkEq("f_invalid_lat", lat, 96);
    ticks(2);
    sendResult(32'h1122_3344, 1'b1, 1'b0);
    checkEq("f_grant2", {30'd0, grant}, 32'd2);

    // Reset during WAIT_DONE, late done is ignored
    ticks(110);
    reqWait(2'b01, 1'b1, lat, sawStart, gotGrant);
    ticks(3);
    rst = 1'b1;
    #1;
    checkEq("g_reset_outs", {27'd0, grant, err, busy, dhtStart}, 32'd0);
    ticks(1);
    dhtData = 32'h5555_AAAA;
    dhtDone = 1'b1;
    ticks(1);
    dhtDone = 1'b0;
    rst = 1'b0;
    ticks(2);
    checkEq("g_no_grant", {27'd0, grant, err, busy, dhtStart}, 32'd0);
    checkEq("g_data", data, 32'd0);
    reqWait(2'b10, 1'b1, lat, sawStart, gotGrant);
    checkEq("g_start_lat", lat, 2);
    ticks(2);
    sendResult(32'h2A00_1500, 1'b1, 1'b0);
    checkEq("g_grant", {30'd0, grant}, 32'd2);
    checkEq("g_data2", data, 32'h2A00_1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dht_read_scheduler.md
Name: dht_read_scheduler

Overview:
- Shares one DHT11 reader among N_REQ requesters, such as the UART command path and a periodic logger.
- Sits between the requesters and the dht11 instance.
- Enforces the sensor's minimum interval between reads and answers requests inside that interval from a cached last-good sample.
- One sensor transaction serves every requester pending when the transaction starts.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- MIN_GAP_CYCLES, 50_000_000, minimum clocks from one read completing to the next start (1 s at 50 MHz).
- TIMEOUT_CYCLES, 5_000_000, maximum clocks from o_Dht_Start to i_Dht_Done or i_Dht_Error before the read is declared failed.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req  in  N_REQ  one-cycle request pulse per requester.
- o_Grant  out  N_REQ  one-cycle pulse; a set bit means o_Data/o_Error are valid for that requester.
- o_Data  out  32  humidity/temperature word, {hum_int, hum_dec, tmp_int, tmp_dec}.
- o_Error  out  1  qualified by o_Grant; 1 = sensor error or timeout, o_Data holds the stale cache.
- o_Busy  out  1  high in START and WAIT_DONE.
- o_Dht_Start  out  1  one-cycle start pulse to the sensor reader.
- i_Dht_Data  in  32  reader result.
- i_Dht_Done  in  1  reader finished OK, one-cycle pulse.
- i_Dht_Error  in  1  reader failed, one-cycle pulse.

Behaviour:
- Reset values (async, i_Reset=1):
  - o_Grant=0, o_Data=0, o_Error=0, o_Busy=0, o_Dht_Start=0.
  - pending=0, snapshot=0, cache_valid=0.
  - age counter = MIN_GAP_CYCLES (saturated), so the first request triggers a read immediately.
- Pending register:
  - pending |= i_Req every cycle.
  - Bits are cleared only for requesters granted that cycle.
  - A set and a clear in the same cycle: set wins, so the request stays pending.
- Age counter:
  - Cleared on any i_Dht_Done, i_Dht_Error or timeout.
  - Otherwise increments, saturating at MIN_GAP_CYCLES.
  - fresh = cache_valid && age < MIN_GAP_CYCLES.
- FSM states: IDLE, START, WAIT_DONE, RESPOND.
  - IDLE, pending!=0 && fresh: go to RESPOND with snapshot=pending and source=cache (o_Error=0).
  - IDLE, pending!=0 && !fresh && age==MIN_GAP_CYCLES: go to START.
  - IDLE, pending!=0 && !cache_valid && age<MIN_GAP_CYCLES (recent failure): stay in IDLE until the gap expires.
  - START: snapshot=pending, o_Dht_Start=1 for exactly one cycle, timeout counter cleared, go to WAIT_DONE.
  - WAIT_DONE, i_Dht_Done: cache<=i_Dht_Data, cache_valid=1, result error=0, go to RESPOND.
  - WAIT_DONE, i_Dht_Error: cache_valid=0 (cache data retained), result error=1, go to RESPOND.
  - WAIT_DONE, timeout counter reaches TIMEOUT_CYCLES-1 with no done: treated as i_Dht_Error.
  - WAIT_DONE, i_Dht_Done and i_Dht_Error in the same cycle: error wins.
  - RESPOND: o_Grant=snapshot for one cycle, o_Data=cache, o_Error=result error; clear the snapshot bits from pending; return to IDLE.
- Latency:
  - Cache hit: request cycle N gives o_Grant at cycle N+2 (pending register N+1, RESPOND N+2).
  - Sensor read: o_Dht_Start at N+2; grant one cycle after the cycle i_Dht_Done is seen.
- Requests during WAIT_DONE/RESPOND: stay pending, not in the snapshot.
  - If the read succeeded they are served from cache on the next IDLE visit.
- Repeat i_Req from a requester already pending merges into the existing pending bit.
- Stray i_Dht_Done/i_Dht_Error outside WAIT_DONE: ignored by the FSM; the age counter is still cleared.
- o_Data and o_Error hold their values between grants.
- Counter widths: $clog2(MIN_GAP_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1).
- Reset mid-transaction: immediate return to IDLE; a late i_Dht_Done after reset is ignored.

Decomposition:
- Shared package dht_pkg holds:
  - FSM state enum.
  - Data field slice constants: HUM_INT=[31:24], HUM_DEC=[23:16], TMP_INT=[15:8], TMP_DEC=[7:0].
  - Default timing constants.
- One sub-module, sat_counter (parameterised width/limit, clear, saturating increment).
  - Instantiated twice: age counter and timeout counter.

Test Plan (MIN_GAP_CYCLES=100, TIMEOUT_CYCLES=40):
- Post-reset i_Req=01 -> o_Dht_Start 2 cycles later. Return i_Dht_Data=32'h3700_1A00 after 10 cycles -> o_Grant=01, o_Data=32'h37001A00, o_Error=0 the next cycle.
- i_Req=10 at 20 cycles after that done -> no o_Dht_Start; o_Grant=10 with the same data 2 cycles later.
- i_Req=11 in one cycle with the gap expired -> single o_Dht_Start, single o_Grant=11. Then i_Req=01 pulsed during WAIT_DONE -> served from cache right after RESPOND.
- No response after start -> o_Grant with o_Error=1 exactly 40 cycles after o_Dht_Start. A new request within 100 cycles gets no start until the age counter saturates.
- i_Dht_Done and i_Dht_Error asserted together -> o_Error=1, cache_valid=0, o_Data unchanged.
- i_Reset pulsed during WAIT_DONE, then i_Dht_Done -> all outputs 0, no grant. The next request starts a read immediately.
